// File: rtl/interrupt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_ctrl
//  Purpose  : Interrupt front end for the opcode/control FSM. Synchronises
//             the active-low NMI/IRQ/RES pins, edge-detects NMI (with a
//             one-deep queue), masks IRQ with the I flag plus a short
//             post-service holdoff, and glitch-filters reset. Presents
//             registered, prioritised (rst > nmi > irq) request levels.
//  Ports    : phi1        - clock, rising edge
//             rst         - asynchronous active-low reset
//             nmi_n/irq_n/res_n - raw active-low interrupt pins
//             statusI     - I flag (1 = IRQ masked)
//             nmiHandled/irqHandled/rstHandled - end-of-sequence pulses
//             rstReq/nmi/irq - request levels to the FSM
//             intPending  - any request active
//             intSel      - 00 none, 01 irq, 10 nmi, 11 rst
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int RST_MIN     = 2,
    parameter int IRQ_HOLDOFF = 2
) (
    input  logic       phi1,
    input  logic       rst,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       res_n,
    input  logic       statusI,
    input  logic       nmiHandled,
    input  logic       irqHandled,
    input  logic       rstHandled,
    output logic       rstReq,
    output logic       nmi,
    output logic       irq,
    output logic       intPending,
    output logic [1:0] intSel
);

    localparam logic [3:0] c_RST_MIN = 4'(RST_MIN);
    localparam logic [2:0] c_HOLD    = 3'(IRQ_HOLDOFF);

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_COUNT   = 2'd1,
        R_PEND    = 2'd2,
        R_WAITREL = 2'd3
    } rstate_t;

    // ------------------------------------------------------------------
    // Pin synchronisers (idle value 1 = deasserted)
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic [SYNC_STAGES-1:0] r_res_sync;

    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            r_nmi_sync <= '1;
            r_irq_sync <= '1;
            r_res_sync <= '1;
        end else begin
            r_nmi_sync <= {r_nmi_sync[SYNC_STAGES-2:0], nmi_n};
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], irq_n};
            r_res_sync <= {r_res_sync[SYNC_STAGES-2:0], res_n};
        end
    end

    logic w_ns;
    logic w_is;
    logic w_rs;
    assign w_ns = r_nmi_sync[SYNC_STAGES-1];
    assign w_is = r_irq_sync[SYNC_STAGES-1];
    assign w_rs = r_res_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rstate_t    r_state;
    logic [3:0] r_cnt;
    logic       r_prev_ns;
    logic       r_nmi_lat;
    logic       r_nmi_q;
    logic [2:0] r_hold;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    rstate_t    w_state_next;
    logic [3:0] w_cnt_next;
    logic       w_req_next;
    logic       w_rst_entry;
    logic       w_nmi_edge;
    logic       w_lat_next;
    logic       w_q_next;
    logic [2:0] w_hold_next;
    logic       w_nmi_next;
    logic       w_irq_next;
    logic [1:0] w_sel_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            R_IDLE: begin
                if (!w_rs) begin
                    if (RST_MIN == 1) begin
                        w_state_next = R_PEND;
                        w_cnt_next   = 4'd0;
                    end else begin
                        w_state_next = R_COUNT;
                        w_cnt_next   = 4'd1;
                    end
                end
            end
            R_COUNT: begin
                if (w_rs) begin
                    // Pin released before qualifying: glitch rejected
                    w_state_next = R_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (r_cnt + 4'd1 == c_RST_MIN) begin
                    w_state_next = R_PEND;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            R_PEND: begin
                // Pin activity is ignored until the FSM finishes reset
                if (rstHandled) begin
                    w_state_next = w_rs ? R_IDLE : R_WAITREL;
                end
            end
            R_WAITREL: begin
                // Pin still held after reset: wait for release before re-arming
                if (w_rs) begin
                    w_state_next = R_IDLE;
                end
            end
            default: begin
                w_state_next = R_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase

        w_req_next  = (w_state_next == R_PEND);
        w_rst_entry = w_req_next && (r_state != R_PEND);

        // NMI edge latch with a one-deep queue behind it
        w_nmi_edge = r_prev_ns & ~w_ns;
        w_lat_next = r_nmi_lat;
        w_q_next   = r_nmi_q;
        if (w_rst_entry) begin
            w_lat_next = 1'b0;
            w_q_next   = 1'b0;
        end else if (nmiHandled && r_nmi_lat) begin
            if (r_nmi_q) begin
                // Queued edge becomes the active request; a coincident edge refills the queue
                w_lat_next = 1'b1;
                w_q_next   = w_nmi_edge;
            end else begin
                // A coincident new edge keeps the request alive
                w_lat_next = w_nmi_edge;
            end
        end else if (w_nmi_edge) begin
            if (!r_nmi_lat) begin
                w_lat_next = 1'b1;
            end else begin
                w_q_next   = 1'b1;
            end
        end

        // Holdoff covers the lag before the FSM's I-flag write lands
        w_hold_next = r_hold;
        if (w_rst_entry) begin
            w_hold_next = 3'd0;
        end else if (irqHandled) begin
            w_hold_next = c_HOLD;
        end else if (r_hold != 3'd0) begin
            w_hold_next = r_hold - 3'd1;
        end

        w_nmi_next = w_lat_next & ~w_req_next;
        // The handled cycle itself also drops the request, then the holdoff runs
        w_irq_next = ~w_is & ~statusI & (r_hold == 3'd0) & ~irqHandled & ~w_req_next;

        if (w_req_next) begin
            w_sel_next = 2'b11;
        end else if (w_nmi_next) begin
            w_sel_next = 2'b10;
        end else if (w_irq_next) begin
            w_sel_next = 2'b01;
        end else begin
            w_sel_next = 2'b00;
        end
    end

    // ------------------------------------------------------------------
    // Registers and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge phi1 or negedge rst) begin
        if (!rst) begin
            r_state    <= R_IDLE;
            r_cnt      <= 4'd0;
            r_prev_ns  <= 1'b1;
            r_nmi_lat  <= 1'b0;
            r_nmi_q    <= 1'b0;
            r_hold     <= 3'd0;
            rstReq     <= 1'b0;
            nmi        <= 1'b0;
            irq        <= 1'b0;
            intPending <= 1'b0;
            intSel     <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_prev_ns  <= w_ns;
            r_nmi_lat  <= w_lat_next;
            r_nmi_q    <= w_q_next;
            r_hold     <= w_hold_next;
            rstReq     <= w_req_next;
            nmi        <= w_nmi_next;
            irq        <= w_irq_next;
            intPending <= w_req_next | w_nmi_next | w_irq_next;
            intSel     <= w_sel_next;
        end
    end

endmodule
`default_nettype wire
